// File: rtl/unpack_pixels.sv
// unpack_pixels: converts a stream of CSI-2 style payload bytes into 10-bit pixels.
//   Decodes RAW8 (id 0x2A) and RAW10 (id 0x2B) long packets, frame start (0x00) and
//   frame end (0x01) short packets. Any other data id with wc>0 is consumed silently.
//   The RAW10 unpacker is built only when UNPACK_RAW10_EN is defined; otherwise id 0x2B
//   is consumed silently and pix_out[1:0] is always 0.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   data_in/data_valid         - payload byte stream
//   pkt_start, id, wc, hdr_err - decoded header, valid with the pkt_start pulse
//   pix_out/pix_valid          - pixel stream
//   line_start/line_end        - coincident with the first/last pixel of a line
//   frame_start/frame_end      - one-cycle pulses after the matching short packet
//   line_cnt                   - lines completed in this frame (saturating)
//   len_err                    - sticky length/abort error, cleared by frame start
module unpack_pixels #(
   parameter int unsigned LCNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        data_in,
   input  logic              data_valid,
   input  logic              pkt_start,
   input  logic [7:0]        id,
   input  logic [15:0]       wc,
   input  logic              hdr_err,
   output logic [9:0]        pix_out,
   output logic              pix_valid,
   output logic              line_start,
   output logic              line_end,
   output logic              frame_start,
   output logic              frame_end,
   output logic [LCNT_W-1:0] line_cnt,
   output logic              len_err
);

   typedef enum logic [1:0] {IDLE, RAW8, RAW10, SKIP} state_t;

   state_t              r_state;
   state_t              w_next;
   state_t              w_hdr_state;
   logic [15:0]         r_wc;
   logic [15:0]         r_cnt;
   logic [9:0]          r_pix_out;
   logic                r_pix_valid;
   logic                r_line_start;
   logic                r_line_end;
   logic                r_frame_start;
   logic                r_frame_end;
   logic [LCNT_W-1:0]   r_line_cnt;
   logic                r_len_err;
   logic [5:0]          w_id;
   logic                w_accept;
   logic                w_last;
   logic                w_unused_id;

`ifdef UNPACK_RAW10_EN
   logic [2:0]          r_grp;        // position of the next byte within its 5-byte group
   logic [3:0][7:0]     r_msb;        // capture buffer for the group being received
   logic [3:0][7:0]     r_bank_msb;   // emit bank; entry 0 is never read
   logic [7:0]          r_lsb;
   logic [1:0]          r_emit_idx;   // next bank pixel to emit, 0 = bank empty
   logic                r_bank_last;
   logic                w_last_grp;
`endif

   assign w_id        = id[5:0];
   assign w_unused_id = &{1'b0, id[7:6]};
   // The header cycle owns the bus: a byte coincident with pkt_start is not counted.
   assign w_accept    = data_valid & ~pkt_start & (r_state != IDLE);
   assign w_last      = w_accept & (r_cnt == r_wc - 16'd1);
`ifdef UNPACK_RAW10_EN
   // Fewer than 5 bytes remain after this group: it is the last complete one.
   assign w_last_grp  = ({1'b0, r_cnt} + 17'd5) >= {1'b0, r_wc};
`endif

   always_comb begin
      w_hdr_state = IDLE;
      if (wc != 16'd0) begin
         case (w_id)
            6'h00, 6'h01: w_hdr_state = IDLE;
            6'h2A:        w_hdr_state = RAW8;
`ifdef UNPACK_RAW10_EN
            6'h2B:        w_hdr_state = RAW10;
`endif
            default:      w_hdr_state = SKIP;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      if (pkt_start)   w_next = hdr_err ? IDLE : w_hdr_state;
      else if (w_last) w_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wc          <= '0;
         r_cnt         <= '0;
         r_pix_out     <= '0;
         r_pix_valid   <= 1'b0;
         r_line_start  <= 1'b0;
         r_line_end    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_line_cnt    <= '0;
         r_len_err     <= 1'b0;
`ifdef UNPACK_RAW10_EN
         r_grp         <= '0;
         r_msb         <= '0;
         r_bank_msb    <= '0;
         r_lsb         <= '0;
         r_emit_idx    <= '0;
         r_bank_last   <= 1'b0;
`endif
      end else begin
         r_pix_valid   <= 1'b0;
         r_line_start  <= 1'b0;
         r_line_end    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
`ifdef UNPACK_RAW10_EN
         // Pixels 1..3 of a loaded bank drain regardless of headers (abort included).
         if (r_emit_idx != 2'd0) begin
            r_pix_out   <= {r_bank_msb[r_emit_idx], r_lsb[{r_emit_idx, 1'b0} +: 2]};
            r_pix_valid <= 1'b1;
            r_line_end  <= r_bank_last & (r_emit_idx == 2'd3);
            r_emit_idx  <= (r_emit_idx == 2'd3) ? 2'd0 : r_emit_idx + 2'd1;
         end
`endif
         if (pkt_start) begin
            r_wc  <= wc;
            r_cnt <= '0;
`ifdef UNPACK_RAW10_EN
            r_grp <= '0;
            r_msb <= '0;
`endif
            if (!hdr_err) begin
               if (r_state != IDLE) r_len_err <= 1'b1;
               if (w_id == 6'h00) begin
                  r_frame_start <= 1'b1;
                  r_line_cnt    <= '0;
                  r_len_err     <= 1'b0;
               end
               if (w_id == 6'h01) r_frame_end <= 1'b1;
            end
         end else if (w_accept) begin
            r_cnt <= r_cnt + 16'd1;
            if (w_last && (r_line_cnt != '1)) r_line_cnt <= r_line_cnt + LCNT_W'(1);
            if (r_state == RAW8) begin
               r_pix_out    <= {data_in, 2'b00};
               r_pix_valid  <= 1'b1;
               r_line_start <= (r_cnt == 16'd0);
               r_line_end   <= w_last;
            end
`ifdef UNPACK_RAW10_EN
            if (r_state == RAW10) begin
               if (r_grp == 3'd4) begin
                  // Pixel 0 leaves directly with the LSB byte; 1..3 go via the bank.
                  r_grp        <= '0;
                  r_pix_out    <= {r_msb[0], data_in[1:0]};
                  r_pix_valid  <= 1'b1;
                  r_line_start <= (r_cnt == 16'd4);
                  r_lsb        <= data_in;
                  r_bank_msb   <= {r_msb[3], r_msb[2], r_msb[1], 8'h00};
                  r_bank_last  <= w_last_grp;
                  r_emit_idx   <= 2'd1;
               end else begin
                  r_msb[r_grp[1:0]] <= data_in;
                  r_grp             <= r_grp + 3'd1;
               end
               if (w_last && (r_grp != 3'd4)) r_len_err <= 1'b1;
            end
`endif
         end
      end
   end

   assign pix_out     = r_pix_out;
   assign pix_valid   = r_pix_valid;
   assign line_start  = r_line_start;
   assign line_end    = r_line_end;
   assign frame_start = r_frame_start;
   assign frame_end   = r_frame_end;
   assign line_cnt    = r_line_cnt;
   assign len_err     = r_len_err;

endmodule

// File: tb/tb_unpack_pixels.sv
// Testbench for unpack_pixels: randomized packets against a packet-level reference
// model; expected pixels are queued at issue time and checked by a monitor.
module tb_unpack_pixels;

   localparam int unsigned LW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    data_in;
   logic          data_valid;
   logic          pkt_start;
   logic [7:0]    id;
   logic [15:0]   wc;
   logic          hdr_err;
   logic [9:0]    pix_out;
   logic          pix_valid;
   logic          line_start;
   logic          line_end;
   logic          frame_start;
   logic          frame_end;
   logic [LW-1:0] line_cnt;
   logic          len_err;

   unpack_pixels #(.LCNT_W(LW)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .pkt_start(pkt_start), .id(id), .wc(wc), .hdr_err(hdr_err),
      .pix_out(pix_out), .pix_valid(pix_valid), .line_start(line_start),
      .line_end(line_end), .frame_start(frame_start), .frame_end(frame_end),
      .line_cnt(line_cnt), .len_err(len_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] pix;
      logic       ls;
      logic       le;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] pkt_bytes[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         exp_line_cnt = 0;
   logic       exp_len_err = 1'b0;
   logic       gaps = 1'b0;

`ifdef UNPACK_RAW10_EN
   localparam bit RAW10_ON = 1'b1;
`else
   localparam bit RAW10_ON = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: whole-packet view. nsent bytes of pkt_bytes actually delivered;
   // complete says the packet reached its word count.
   task automatic model_packet(input logic [7:0] pid, input int unsigned nwc,
                               input int unsigned nsent, input bit complete);
      exp_t e;
      if (pid == 8'h2A) begin
         for (int unsigned i = 0; i < nsent; i++) begin
            e.pix = {pkt_bytes[i], 2'b00};
            e.ls  = (i == 0);
            e.le  = complete && (i == nwc - 1);
            exp_q.push_back(e);
         end
      end else if (pid == 8'h2B && RAW10_ON) begin
         for (int unsigned g = 0; g < nsent / 5; g++) begin
            for (int unsigned k = 0; k < 4; k++) begin
               e.pix = {pkt_bytes[5*g+k], 2'b00} + 10'((pkt_bytes[5*g+4] >> (2*k)) & 8'h3);
               e.ls  = (g == 0) && (k == 0);
               e.le  = complete && (g == nwc / 5 - 1) && (k == 3);
               exp_q.push_back(e);
            end
         end
         if (complete && (nwc % 5 != 0)) exp_len_err = 1'b1;
      end
      if (complete && nwc > 0 && exp_line_cnt < (1 << LW) - 1) exp_line_cnt++;
   endtask

   task automatic send_hdr(input logic [7:0] pid, input logic [15:0] pwc, input logic herr);
      pkt_start = 1'b1; id = pid; wc = pwc; hdr_err = herr;
      @(posedge clk); #1;
      pkt_start = 1'b0; hdr_err = 1'b0; id = $urandom; wc = $urandom;
   endtask

   task automatic send_bytes(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            data_valid = 1'b0; data_in = $urandom;
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
         end
         data_valid = 1'b1; data_in = pkt_bytes[i];
         @(posedge clk); #1;
      end
      data_valid = 1'b0; data_in = $urandom;
   endtask

   task automatic drain_and_check(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 12) begin @(posedge clk); #1; n++; end
      chk({tag, "_pixels_missing"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (2) begin @(posedge clk); #1; end
      chk({tag, "_line_cnt"}, line_cnt, exp_line_cnt);
      chk({tag, "_len_err"}, len_err, exp_len_err);
   endtask

   task automatic full_packet(input string tag, input logic [7:0] pid, input int unsigned nwc);
      send_hdr(pid, 16'(nwc), 1'b0);
      model_packet(pid, nwc, nwc, 1'b1);
      send_bytes(nwc);
      drain_and_check(tag);
   endtask

   task automatic rand_bytes(input int unsigned n);
      pkt_bytes.delete();
      for (int unsigned i = 0; i < n; i++) pkt_bytes.push_back(8'($urandom));
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (pix_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_pixel actual=%0h required=none", pix_out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pix_out", pix_out, e.pix);
               chk("line_start", line_start, e.ls);
               chk("line_end", line_end, e.le);
            end
         end else if (line_start || line_end) begin
            n_chk++; n_fail++;
            $display("FAIL line_pulse_without_pixel actual=%b%b required=00", line_start, line_end);
         end
      end
   end

   initial begin
      reset = 1'b1; data_in = '0; data_valid = 1'b0; pkt_start = 1'b0;
      id = '0; wc = '0; hdr_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {pix_out, pix_valid, line_start, line_end, frame_start,
                            frame_end, line_cnt, len_err}, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Frame start
      send_hdr(8'h00, 16'd7, 1'b0);
      exp_line_cnt = 0; exp_len_err = 1'b0;
      chk("frame_start_pulse", frame_start, 1);
      chk("frame_start_line_cnt", line_cnt, 0);
      @(posedge clk); #1;
      chk("frame_start_one_cycle", frame_start, 0);

      // RAW8 wc=3
      pkt_bytes = '{8'h11, 8'h22, 8'h33};
      full_packet("raw8_wc3", 8'h2A, 3);

      // RAW10 wc=10
      pkt_bytes = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'hE4, 8'h10, 8'h20, 8'h30, 8'h40, 8'h1B};
      full_packet("raw10_wc10", 8'h2B, 10);

      // RAW10 wc=7: trailing partial group
      pkt_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
      full_packet("raw10_wc7", 8'h2B, 7);

      // Frame end, then a new frame clears len_err and line_cnt
      send_hdr(8'h01, 16'd0, 1'b0);
      chk("frame_end_pulse", frame_end, 1);
      send_hdr(8'h00, 16'd0, 1'b0);
      exp_line_cnt = 0; exp_len_err = 1'b0;
      chk("frame_start_clears_len_err", len_err, 0);

      // Header error: packet ignored
      rand_bytes(5);
      send_hdr(8'h2B, 16'd5, 1'b1);
      send_bytes(5);
      drain_and_check("hdr_err");

      // Zero word count data packet: nothing happens
      send_hdr(8'h2A, 16'd0, 1'b0);
      rand_bytes(2);
      send_bytes(2);
      drain_and_check("wc0");

      // Abort RAW8 mid-packet with a new header
      rand_bytes(4);
      send_hdr(8'h2A, 16'd4, 1'b0);
      model_packet(8'h2A, 4, 2, 1'b0);
      send_bytes(2);
      exp_len_err = 1'b1;
      rand_bytes(2);
      full_packet("abort_then_raw8", 8'h2A, 2);

      // Randomized packets, with gaps; line_cnt saturates at 3
      gaps = 1'b1;
      for (int t = 0; t < 24; t++) begin
         int unsigned kind;
         int unsigned n;
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            n = $urandom_range(1, 12); rand_bytes(n); full_packet("rnd_raw8", 8'h2A, n);
         end else if (kind == 3) begin
            n = $urandom_range(1, 8); rand_bytes(n); full_packet("rnd_skip", 8'h12, n);
         end else begin
            n = $urandom_range(1, 22); rand_bytes(n); full_packet("rnd_raw10", 8'h2B, n);
         end
      end
      gaps = 1'b0;

      // Reset in the middle of a RAW10 group / emission
      rand_bytes(10);
      send_hdr(8'h2B, 16'd10, 1'b0);
      model_packet(8'h2B, 10, 6, 1'b0);
      send_bytes(6);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_group_reset_outputs", {pix_out, pix_valid, line_start, line_end, frame_start,
                                      frame_end, line_cnt, len_err}, 0);
      exp_q.delete();
      exp_line_cnt = 0; exp_len_err = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      rand_bytes(4);
      send_bytes(4);
      drain_and_check("after_reset_idle");
      rand_bytes(5);
      full_packet("after_reset_raw10", 8'h2B, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/unpack_pixels.md
UNPACK_PIXELS -- requirements
Module: unpack_pixels

Interface
REQ-001 SHALL have parameter LCNT_W, default 16, the width of the line counter.
REQ-002 SHALL have clk, input, 1, the single clock for all logic.
REQ-003 SHALL have reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have data_in, input, 8, payload byte from the packet stripper.
REQ-005 SHALL have data_valid, input, 1, data_in is a valid payload byte this cycle.
REQ-006 SHALL have pkt_start, input, 1, one-cycle pulse marking that id/wc carry a new decoded header.
REQ-007 SHALL have id, input, 8, data identifier; only id[5:0] is decoded.
REQ-008 SHALL have wc, input, 16, word count in bytes, valid with pkt_start.
REQ-009 SHALL have hdr_err, input, 1, uncorrectable header error, valid with pkt_start.
REQ-010 SHALL have pix_out, output, 10, pixel value.
REQ-011 SHALL have pix_valid, output, 1, pix_out is valid this cycle.
REQ-012 SHALL have line_start and line_end, output, 1 each, pulses coincident with the first and last pixel of a line.
REQ-013 SHALL have frame_start and frame_end, output, 1 each, one-cycle pulses.
REQ-014 SHALL have line_cnt, output, LCNT_W, count of completed lines in the current frame.
REQ-015 SHALL have len_err, output, 1, sticky payload length/abort error.

Function
REQ-016 SHALL provide FSM states IDLE, RAW8, RAW10, SKIP; captures id/wc only on pkt_start with hdr_err=0, from any state.
REQ-017 SHALL ignore pkt_start with hdr_err=1 (state -> IDLE) and ignore data_valid in IDLE.
REQ-018 SHALL decode id[5:0]: 0x00 -> frame_start pulse next cycle, line_cnt<=0, len_err<=0; 0x01 -> frame_end pulse next cycle; both stay IDLE.
REQ-019 SHALL decode 0x2A -> RAW8, 0x2B -> RAW10, any other id with wc>0 -> SKIP; data id with wc=0 -> IDLE, no pixels, no pulses.
REQ-020 SHALL count accepted bytes; on the wc-th byte it returns to IDLE and increments line_cnt (saturates at all-ones).
REQ-021 RAW8: SHALL emit pix_out={data_in,2'b00} with pix_valid one cycle after each accepted byte.
REQ-022 RAW10: SHALL store bytes 0-3 of each 5-byte group as MSBs; byte 4 (LSBs) moves the group into an emit bank.
REQ-023 RAW10: SHALL emit pixel k={msb[k], lsb[2k+1:2k]}, k=0..3, on four consecutive cycles starting one cycle after byte 4.
REQ-024 RAW10: SHALL capture the next group's MSBs into a separate buffer while the emit bank drains; back-to-back data_valid never loses pixels.
REQ-025 SHALL assert line_start with the first pixel of a line and line_end with its last pixel (RAW10: pixel 3 of the last complete group).
REQ-026 RAW10 wc not a multiple of 5: SHALL set len_err, discard the trailing partial group, and place line_end on the last complete group; with no complete group there is no line_start or line_end.
REQ-027 SHALL treat pkt_start with hdr_err=0 while in RAW8/RAW10/SKIP as an abort: set len_err, drop partial MSBs, no line_end, line_cnt unchanged; an emit bank already loaded still drains.
REQ-028 SHALL output no pixels in SKIP; SKIP bytes still count toward wc.

Reset
REQ-029 SHALL on reset: state IDLE, pix_out=0, pix_valid=0, all pulses 0, line_cnt=0, len_err=0, counters and buffers cleared; reset overrides mid-group or mid-emission activity.

Configuration
REQ-030 SHALL compile the RAW10 path only when macro UNPACK_RAW10_EN is defined; without it, id 0x2B is routed to SKIP, no RAW10 buffers exist and pix_out[1:0] is always 0.

Verification
REQ-031 SHALL pass: pkt_start id=0x00 -> frame_start pulse next cycle, line_cnt=0.
REQ-032 SHALL pass: id=0x2A wc=3, bytes 0x11,0x22,0x33 back-to-back -> pix_out 0x044,0x088,0x0CC; line_start on 1st, line_end on 3rd; line_cnt=1.
REQ-033 SHALL pass: id=0x2B wc=10, bytes FF,00,80,01,E4 then 10,20,30,40,1B back-to-back -> first group 0x3FC,0x001,0x202,0x007, then 0x043,0x082,0x0C1,0x100; eight contiguous pix_valid cycles, line_end on the 8th pixel.
REQ-034 SHALL pass: id=0x2B wc=7 -> 4 pixels, line_end on 4th, len_err=1, 2 trailing bytes dropped.
REQ-035 SHALL pass: pkt_start id=0x2B wc=5 with hdr_err=1 followed by 5 bytes -> no pix_valid, line_cnt unchanged; reset asserted mid-RAW10 group -> all outputs 0 the next cycle.
